// File: rtl/uart_rx_fifo_if.sv
// Byte-stream handshake between the UART receiver, the receive FIFO and its consumer.
// The FIFO takes the slave modport. The environment (receiver plus host side) takes master.
interface uart_rx_fifo_if #(
   parameter int DATA_W = 8
);
   logic              in_vld;
   logic [DATA_W-1:0] in_data;
   logic              in_rdy;
   logic              out_vld;
   logic [DATA_W-1:0] out_data;
   logic              out_rdy;

   modport master (
      output in_vld,
      output in_data,
      output out_rdy,
      input  in_rdy,
      input  out_vld,
      input  out_data
   );

   modport slave (
      input  in_vld,
      input  in_data,
      input  out_rdy,
      output in_rdy,
      output out_vld,
      output out_data
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO sitting behind the UART receiver.
// Besides buffering, it raises three interrupt sources:
//  - overrun: sticky, set when a byte is dropped because the FIFO is full
//  - threshold: occupancy at or above a programmable level
//  - idle timeout: data is pending and there has been no push or pop for a programmed time
// The receiver is never back-pressured for fullness. It would overwrite its own holding
// register anyway, so a full FIFO drops the byte and records an overrun instead.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DATA_W     = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  cfg_en_i,
   input  logic [DEPTH_LOG2:0]   cfg_thresh_i,
   input  logic [15:0]           cfg_timeout_i,
   input  logic                  clr_i,
   input  logic                  ovr_clr_i,
   uart_rx_fifo_if.slave         bus,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  overrun_o,
   output logic                  irq_thresh_o,
   output logic                  irq_timeout_o
);

   localparam int                     DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]    LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]    LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0]  PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [15:0]            TIMER_MAX  = 16'hFFFF;

   // Storage and state registers
   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [15:0]           timer_q, timer_d;
   logic                  overrun_q, overrun_d;
   logic                  irq_timeout_q, irq_timeout_d;

   // Per-cycle events
   logic flush;
   logic push;
   logic pop;
   logic wr_en;
   logic drop;
   logic is_empty;
   logic is_full;

   // Event decoding. A disabled block behaves as a flush held every cycle.
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a
   // push that coincides with a pop.
   always_comb begin
      is_empty = (level_q == '0);
      is_full  = (level_q == LEVEL_FULL);
      flush    = clr_i | ~cfg_en_i;
      push     = bus.in_vld & cfg_en_i & ~clr_i;
      pop      = ~is_empty & bus.out_rdy & ~flush;
      wr_en    = push & (~is_full | pop);
      drop     = push & is_full & ~pop;
   end

   // Pointer and occupancy update. Level is its own counter, so the
   // pointers only need to wrap modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (wr_en && !pop) begin
            level_d = level_q + LEVEL_ONE;
         end else if (pop && !wr_en) begin
            level_d = level_q - LEVEL_ONE;
         end
      end
   end

   // Idle timer: counts cycles with data pending and no traffic, and saturates at the top.
   always_comb begin
      timer_d = timer_q;
      if (flush || push || pop || is_empty) begin
         timer_d = '0;
      end else if (timer_q != TIMER_MAX) begin
         timer_d = timer_q + 16'd1;
      end
   end

   // Timeout flag: raised on the cycle the timer reaches its limit, then held until traffic or a flush.
   always_comb begin
      irq_timeout_d = irq_timeout_q;
      if (flush || push || pop) begin
         irq_timeout_d = 1'b0;
      end else if (cfg_timeout_i != '0 && !is_empty &&
                   timer_q == cfg_timeout_i - 16'd1) begin
         irq_timeout_d = 1'b1;
      end
   end

   // Sticky overrun. A new drop beats a simultaneous clear. A plain flush leaves it alone, but disabling the block clears it.
   always_comb begin
      overrun_d = overrun_q;
      if (!cfg_en_i) begin
         overrun_d = 1'b0;
      end else if (drop) begin
         overrun_d = 1'b1;
      end else if (ovr_clr_i) begin
         overrun_d = 1'b0;
      end
   end

   // Control state registers, all cleared by the asynchronous reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         timer_q       <= '0;
         overrun_q     <= 1'b0;
         irq_timeout_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         timer_q       <= timer_d;
         overrun_q     <= overrun_d;
         irq_timeout_q <= irq_timeout_d;
      end
   end

   // Byte storage. It has no reset because its contents only matter below the level count.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= bus.in_data;
      end
   end

   // Output mapping. Threshold is combinational so a threshold change is seen at once.
   always_comb begin
      bus.in_rdy    = cfg_en_i;
      bus.out_vld   = ~is_empty;
      bus.out_data  = mem_q[rd_ptr_q];
      level_o       = level_q;
      empty_o       = is_empty;
      full_o        = is_full;
      overrun_o     = overrun_q;
      irq_timeout_o = irq_timeout_q;
      irq_thresh_o  = (cfg_thresh_i != '0) && (level_q >= cfg_thresh_i);
   end

endmodule
